// File: rtl/load_seq_pkg.sv
// Shared definitions for the boot-load sequencer: state encoding and failure codes.
// Also meant for the supervisor and status-register logic that decode fail_code.
package load_seq_pkg;

  // State encoding, kept as named constants so status logic can decode a mirrored state
  localparam logic [2:0] ENC_IDLE       = 3'd0;
  localparam logic [2:0] ENC_FLASH_REQ  = 3'd1;
  localparam logic [2:0] ENC_FLASH_WAIT = 3'd2;
  localparam logic [2:0] ENC_FRAM_REQ   = 3'd3;
  localparam logic [2:0] ENC_FRAM_WAIT  = 3'd4;
  localparam logic [2:0] ENC_GAP        = 3'd5;
  localparam logic [2:0] ENC_DONE       = 3'd6;
  localparam logic [2:0] ENC_FAIL       = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = ENC_IDLE,
    ST_FLASH_REQ  = ENC_FLASH_REQ,
    ST_FLASH_WAIT = ENC_FLASH_WAIT,
    ST_FRAM_REQ   = ENC_FRAM_REQ,
    ST_FRAM_WAIT  = ENC_FRAM_WAIT,
    ST_GAP        = ENC_GAP,
    ST_DONE       = ENC_DONE,
    ST_FAIL       = ENC_FAIL
  } state_t;

  // Last-failure cause reported on fail_code
  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_FLASH_ERR = 3'd1;
  localparam logic [2:0] FC_FLASH_TO  = 3'd2;
  localparam logic [2:0] FC_FRAM_ERR  = 3'd3;
  localparam logic [2:0] FC_FRAM_TO   = 3'd4;

endpackage

// File: rtl/load_seq_ctrl_if.sv
// Handshake and status bundle between the load sequencer and its surroundings
// (supervisor start/status, flash and FRAM load FSM strobes and responses).
interface load_seq_ctrl_if;
  logic       load_start;
  logic       flash_fsm_en;
  logic       flash_fsm_done;
  logic       flash_fsm_error;
  logic       fram_fsm_en;
  logic       fram_fsm_done;
  logic       fram_fsm_error;
  logic       load_busy;
  logic       load_done;
  logic       load_error;
  logic [2:0] fail_code;
  logic [2:0] retry_cnt;

  // Sequencer side
  modport master (
    input  load_start, flash_fsm_done, flash_fsm_error, fram_fsm_done, fram_fsm_error,
    output flash_fsm_en, fram_fsm_en, load_busy, load_done, load_error, fail_code, retry_cnt
  );

  // Environment side (supervisor plus the two load FSMs)
  modport slave (
    output load_start, flash_fsm_done, flash_fsm_error, fram_fsm_done, fram_fsm_error,
    input  flash_fsm_en, fram_fsm_en, load_busy, load_done, load_error, fail_code, retry_cnt
  );
endinterface

// File: rtl/load_stage_wdt.sv
// Shared stage counter: watchdog during the WAIT states, back-off counter during GAP.
// hit compares against a limit chosen at runtime by the sequencer.
module load_stage_wdt #(
  parameter int TO_W = 26
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            clr,
  input  logic            inc,
  input  logic [TO_W-1:0] limit,
  output logic            hit
);

  logic [TO_W-1:0] cnt_reg;

  // Counter: clear wins over increment, holds otherwise
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + TO_W'(1);
    end
  end

  assign hit = (cnt_reg == limit);

endmodule

// File: rtl/load_seq_ctrl.sv
// Boot-load sequencer: flash stage then FRAM stage, per-stage watchdog,
// bounded full-sequence retry with back-off, sticky done/error and failure code.
module load_seq_ctrl
  import load_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 1024
) (
  input logic             sys_clk,
  input logic             glbl_rst,
  load_seq_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] GAP_LIMIT = TO_W'(GAP_CYC - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  state_t          state_reg, state_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            error_reg, error_next;
  logic [2:0]      code_reg, code_next;
  logic [2:0]      retry_reg, retry_next;

  logic            wdt_clr, wdt_inc, wdt_hit;
  logic [TO_W-1:0] wdt_limit;
  logic            flash_en, fram_en;
  logic            fail_now;
  logic [2:0]      fail_cause;

  load_stage_wdt #(.TO_W(TO_W)) u_wdt (
    .clk   (sys_clk),
    .srst  (glbl_rst),
    .clr   (wdt_clr),
    .inc   (wdt_inc),
    .limit (wdt_limit),
    .hit   (wdt_hit)
  );

  // State and sticky status registers
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      code_reg  <= FC_NONE;
      retry_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      code_reg  <= code_next;
      retry_reg <= retry_next;
    end
  end

  // Next state, status updates, watchdog control and strobes
  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    error_next = error_reg;
    code_next  = code_reg;
    retry_next = retry_reg;
    wdt_clr    = 1'b0;
    wdt_inc    = 1'b0;
    wdt_limit  = TO_LIMIT;
    flash_en   = 1'b0;
    fram_en    = 1'b0;
    fail_now   = 1'b0;
    fail_cause = FC_NONE;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.load_start) begin
          state_next = ST_FLASH_REQ;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          error_next = 1'b0;
          code_next  = FC_NONE;
          retry_next = 3'd0;
        end
      end
      ST_FLASH_REQ: begin
        flash_en   = 1'b1;
        wdt_clr    = 1'b1;
        state_next = ST_FLASH_WAIT;
      end
      ST_FLASH_WAIT: begin
        // error beats done, done beats the timeout compare
        if (bus.flash_fsm_error) begin
          fail_now   = 1'b1;
          fail_cause = FC_FLASH_ERR;
        end else if (bus.flash_fsm_done) begin
          state_next = ST_FRAM_REQ;
        end else if (wdt_hit) begin
          fail_now   = 1'b1;
          fail_cause = FC_FLASH_TO;
        end else begin
          wdt_inc = 1'b1;
        end
      end
      ST_FRAM_REQ: begin
        fram_en    = 1'b1;
        wdt_clr    = 1'b1;
        state_next = ST_FRAM_WAIT;
      end
      ST_FRAM_WAIT: begin
        if (bus.fram_fsm_error) begin
          fail_now   = 1'b1;
          fail_cause = FC_FRAM_ERR;
        end else if (bus.fram_fsm_done) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else if (wdt_hit) begin
          fail_now   = 1'b1;
          fail_cause = FC_FRAM_TO;
        end else begin
          wdt_inc = 1'b1;
        end
      end
      ST_GAP: begin
        wdt_limit = GAP_LIMIT;
        if (wdt_hit) begin
          state_next = ST_FLASH_REQ;
        end else begin
          wdt_inc = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Common failure handling: record cause, then retry via GAP or give up
    if (fail_now) begin
      code_next = fail_cause;
      wdt_clr   = 1'b1;
      if (retry_reg < RETRY_MAX) begin
        retry_next = retry_reg + 3'd1;
        state_next = ST_GAP;
      end else begin
        state_next = ST_FAIL;
        error_next = 1'b1;
        busy_next  = 1'b0;
      end
    end
  end

  assign bus.flash_fsm_en = flash_en;
  assign bus.fram_fsm_en  = fram_en;
  assign bus.load_busy    = busy_reg;
  assign bus.load_done    = done_reg;
  assign bus.load_error   = error_reg;
  assign bus.fail_code    = code_reg;
  assign bus.retry_cnt    = retry_reg;

endmodule

// File: doc/load_seq_ctrl.md
# load_seq_ctrl

Top-level boot-load sequencer for the PFPGA load path. On one start pulse it runs the flash load stage and then the FRAM load stage. FRAM loading covers the AFPGA image and the constants. Each stage has a watchdog timeout. On failure the whole sequence is retried a bounded number of times, and the block reports a sticky done/error status with a failure code. It sits between the board supervisor logic and the existing flash and FRAM load FSMs, and owns their enable strobes.

## Interface
- `TIMEOUT_CYC`, 50_000_000: per-stage watchdog limit in sys_clk cycles (1 s at 50 MHz); must be ≥ 2.
- `TO_W`, 26: watchdog counter width; 2^TO_W ≥ TIMEOUT_CYC.
- `MAX_RETRY`, 2: full-sequence retries after the first attempt; range 0..7.
- `GAP_CYC`, 1024: idle back-off cycles before each retry; must be ≥ 1.
- `sys_clk` in 1: single clock, all logic on the rising edge.
- `glbl_rst` in 1: synchronous, active-high reset.
- `load_start` in 1: start request; sampled only in IDLE, DONE or FAIL.
- `flash_fsm_en` out 1: one-cycle strobe starting the flash load FSM.
- `flash_fsm_done` in 1: flash stage complete (pulse).
- `flash_fsm_error` in 1: flash stage error (pulse or level).
- `fram_fsm_en` out 1: one-cycle strobe to the FRAM load FSM's `load_ram_en`.
- `fram_fsm_done` in 1: FRAM stage complete.
- `fram_fsm_error` in 1: FRAM stage error.
- `load_busy` out 1: high from the start strobe until DONE or FAIL.
- `load_done` out 1: sticky success; cleared by the next accepted `load_start`.
- `load_error` out 1: sticky final failure; cleared likewise.
- `fail_code` out 3: last failure cause. 0 none, 1 flash error, 2 flash timeout, 3 FRAM error, 4 FRAM timeout.
- `retry_cnt` out 3: retries consumed in the current or last run.

## Operation
- States: IDLE, FLASH_REQ, FLASH_WAIT, FRAM_REQ, FRAM_WAIT, GAP, DONE, FAIL.
- IDLE/DONE/FAIL with `load_start`=1 → FLASH_REQ.
  - Clears `load_done`, `load_error`, `fail_code` and `retry_cnt`.
  - Sets `load_busy`.
- FLASH_REQ: `flash_fsm_en`=1 for exactly this cycle; clears the watchdog; → FLASH_WAIT.
- FLASH_WAIT, evaluated in priority order:
  - error → fail(1).
  - done → FRAM_REQ.
  - watchdog == TIMEOUT_CYC−1 → fail(2).
  - otherwise, watchdog +1.
- FRAM_REQ: `fram_fsm_en`=1 for one cycle; clears the watchdog; → FRAM_WAIT.
- FRAM_WAIT: same priority rule with codes 3 and 4. Done → DONE, setting `load_done` and clearing `load_busy`.
- fail(c): `fail_code` ← c.
  - If `retry_cnt` < MAX_RETRY: `retry_cnt` +1, → GAP. The watchdog is reused as the gap counter.
  - Otherwise: → FAIL, setting `load_error` and clearing `load_busy`.
- GAP: counts GAP_CYC cycles, then → FLASH_REQ. A retry always restarts from the flash stage.
- `fail_code` keeps the most recent cause even if a later retry succeeds. It is cleared only by a new start or reset.
- `load_start` is ignored while busy, including in GAP.
- Done/error inputs arriving outside their WAIT state are ignored.
- Error and done in the same cycle: error wins.
- Done in the same cycle as the timeout compare: done wins.

## Timing
- Reset, at the next edge with `glbl_rst`=1:
  - State → IDLE.
  - All outputs 0: strobes, busy, done, error, `fail_code`, `retry_cnt`.
- Reset mid-sequence aborts immediately. No strobe is issued afterwards.
- `load_start` high in cycle N:
  - `flash_fsm_en` high in cycle N+1.
  - `load_busy` high from cycle N+1.
- `flash_fsm_done` high in cycle M → `fram_fsm_en` high in cycle M+1.
- `fram_fsm_done` high in cycle K → `load_done`=1 and `load_busy`=0 in cycle K+1.
- Watchdog: the WAIT state is entered in cycle W with count 0. Timeout is detected in cycle W+TIMEOUT_CYC−1; the next state takes effect at W+TIMEOUT_CYC.
- Retry: from the cycle after fail, GAP lasts GAP_CYC cycles, then a one-cycle FLASH_REQ.
- Strobes are never high for two consecutive cycles.
- `flash_fsm_en` and `fram_fsm_en` are never high together.

## Structure
- Shared package `load_seq_pkg` holds:
  - the state encoding localparams;
  - the `fail_code` constants FC_NONE, FC_FLASH_ERR, FC_FLASH_TO, FC_FRAM_ERR, FC_FRAM_TO.
- The package is reusable by the supervisor and status-register logic.
- One sub-module, `load_stage_wdt`: a TO_W-bit counter with `clr`, `inc` and a `hit` compare against a runtime limit input.
  - Instantiated once; serves both the stage timeout and the GAP count.
- The FSM and status registers live in the top module.

## Test plan
All scenarios use TIMEOUT_CYC=16, MAX_RETRY=1, GAP_CYC=4.

- **Nominal:** start at cycle 0; flash done at cycle 5; FRAM done at cycle 12.
  - Required: `flash_fsm_en` at 1, `fram_fsm_en` at 6, `load_done`=1 at 13, `fail_code`=0, `retry_cnt`=0.
- **Flash error then success:** flash error on the first attempt.
  - Required: `retry_cnt`=1, then 4 GAP cycles, then a second `flash_fsm_en`; that run completes.
  - End state: `load_done`=1, `fail_code`=1.
- **Double FRAM timeout:** flash done, FRAM never answers.
  - Required: timeout 16 cycles after each `fram_fsm_en`, one retry.
  - End state: `load_error`=1, `fail_code`=4, `retry_cnt`=1, `load_busy`=0.
- **Simultaneous events:** `fram_fsm_done` and `fram_fsm_error` in the same cycle → error path taken (code 3). Done exactly on watchdog cycle 15 → success, no timeout.
- **Start while busy:** a `load_start` pulse during FLASH_WAIT and another during GAP.
  - Required: no extra strobe, status unchanged.
  - A restart from DONE clears `load_done` in the next cycle.
- **Reset mid-FRAM_WAIT:** all outputs 0 at the next edge; stray `fram_fsm_done` afterwards is ignored.
